// File: rtl/ps2_scan_code_decoder_pkg.sv
// Shared constants and types for the PS/2 scan-code decoder:
// prefix bytes, frame length, receiver FSM states and the frame validity check.
package ps2_scan_code_decoder_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } ps2_state_e;

    // Frame layout after LSB-first capture: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
    function automatic logic frame_is_good(input logic [PS2_FRAME_BITS-1:0] f);
        return ~f[0] & f[10] & (^f[9:1]);
    endfunction

endpackage

// File: rtl/ps2_scan_code_decoder_frame_rx.sv
// Framed PS/2 receiver: falling-edge detect, 11-bit capture with mid-frame timeout,
// and a one-cycle CHECK state that reports the byte with ok/error strobes.
module ps2_scan_code_decoder_frame_rx
    import ps2_scan_code_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       frame_ok_o,
    output logic       check_err_o,
    output logic       timeout_err_o
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    ps2_state_e                state_q;
    logic                      prev_clk_q;
    logic [3:0]                bit_cnt_q;
    logic [PS2_FRAME_BITS-1:0] shift_q;
    logic [TO_W-1:0]           to_cnt_q;

    logic fall_edge;
    logic timeout_hit;
    logic frame_good;

    assign fall_edge   = prev_clk_q & ~ps2_clk_i;
    assign timeout_hit = (state_q == RECV) && !fall_edge && (to_cnt_q == TO_LAST);
    assign frame_good  = frame_is_good(shift_q);

    assign byte_o        = shift_q[8:1];
    assign frame_ok_o    = (state_q == CHECK) &&  frame_good;
    assign check_err_o   = (state_q == CHECK) && !frame_good;
    assign timeout_err_o = timeout_hit;

    // Bits enter at the MSB so that after exactly 11 shifts the start bit sits at [0].
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            prev_clk_q <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            to_cnt_q   <= '0;
        end else begin
            prev_clk_q <= ps2_clk_i;
            case (state_q)
                IDLE: begin
                    if (fall_edge && !ps2_data_i) begin
                        shift_q   <= {ps2_data_i, shift_q[PS2_FRAME_BITS-1:1]};
                        bit_cnt_q <= 4'd1;
                        to_cnt_q  <= '0;
                        state_q   <= RECV;
                    end
                end
                RECV: begin
                    if (fall_edge) begin
                        shift_q   <= {ps2_data_i, shift_q[PS2_FRAME_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        to_cnt_q  <= '0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= CHECK;
                        end
                    end else if (timeout_hit) begin
                        to_cnt_q <= '0;
                        state_q  <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                CHECK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_code_decoder.sv
// PS/2 scan-code decoder top: folds E0/F0 prefixes into one key event per keystroke
// and registers the key/error outputs from the framed receiver.
module ps2_scan_code_decoder
    import ps2_scan_code_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       PS2_CLK_DB,
    input  logic       PS2_DATA_DB,
    output logic [7:0] KEY_CODE,
    output logic       KEY_EXTENDED,
    output logic       KEY_RELEASE,
    output logic       KEY_VALID,
    output logic       FRAME_ERROR
);

    logic [7:0] rx_byte;
    logic       rx_ok;
    logic       rx_check_err;
    logic       rx_timeout_err;

    logic       ext_q;
    logic       brk_q;
    logic [7:0] key_code_q;
    logic       key_ext_q;
    logic       key_rel_q;
    logic       key_valid_q;
    logic       frame_error_q;

    ps2_scan_code_decoder_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_frame_rx (
        .clk_i         (CLK),
        .rst_ni        (RESET_N),
        .ps2_clk_i     (PS2_CLK_DB),
        .ps2_data_i    (PS2_DATA_DB),
        .byte_o        (rx_byte),
        .frame_ok_o    (rx_ok),
        .check_err_o   (rx_check_err),
        .timeout_err_o (rx_timeout_err)
    );

    // A timeout keeps pending prefixes; a corrupted frame discards them.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            key_code_q    <= '0;
            key_ext_q     <= 1'b0;
            key_rel_q     <= 1'b0;
            key_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            key_valid_q   <= 1'b0;
            frame_error_q <= rx_check_err | rx_timeout_err;
            if (rx_check_err) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (rx_ok) begin
                if (rx_byte == PS2_PREFIX_EXT) begin
                    ext_q <= 1'b1;
                end else if (rx_byte == PS2_PREFIX_BRK) begin
                    brk_q <= 1'b1;
                end else begin
                    key_code_q  <= rx_byte;
                    key_ext_q   <= ext_q;
                    key_rel_q   <= brk_q;
                    key_valid_q <= 1'b1;
                    ext_q       <= 1'b0;
                    brk_q       <= 1'b0;
                end
            end
        end
    end

    assign KEY_CODE     = key_code_q;
    assign KEY_EXTENDED = key_ext_q;
    assign KEY_RELEASE  = key_rel_q;
    assign KEY_VALID    = key_valid_q;
    assign FRAME_ERROR  = frame_error_q;

endmodule

// File: tb/tb_ps2_scan_code_decoder.sv
// Testbench for ps2_scan_code_decoder: drives PS/2 frames with a 40-CLK bit period
// and scoreboards every KEY_VALID / FRAME_ERROR strobe against a prefix-folding model.
module tb_ps2_scan_code_decoder;

   localparam int TIMEOUT = 50000;
   localparam int HALF_BIT = 20;

   logic       clock;
   logic       resetN;
   logic       ps2Clk;
   logic       ps2Data;
   logic [7:0] keyCode;
   logic       keyExtended;
   logic       keyRelease;
   logic       keyValid;
   logic       frameError;

   typedef struct {
      bit         isErr;
      logic [7:0] code;
      bit         ext;
      bit         rel;
      int         due;
   } expEvent_t;

   expEvent_t expQ[$];

   int errCount   = 0;
   int checkCount = 0;
   int cycleCnt   = 0;

   bit         modelExt = 0;
   bit         modelRel = 0;
   logic [7:0] lastCode = 8'h00;
   bit         lastExt  = 0;
   bit         lastRel  = 0;

   ps2_scan_code_decoder #(
      .TIMEOUT_CYCLES (TIMEOUT),
      .TO_W           (16)
   ) dut (
      .CLK          (clock),
      .RESET_N      (resetN),
      .PS2_CLK_DB   (ps2Clk),
      .PS2_DATA_DB  (ps2Data),
      .KEY_CODE     (keyCode),
      .KEY_EXTENDED (keyExtended),
      .KEY_RELEASE  (keyRelease),
      .KEY_VALID    (keyValid),
      .FRAME_ERROR  (frameError)
   );

   // 100 MHz-style system clock; period 10 time units
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cycleCnt);
      end
   endtask

   // Frame bits in transmit order: start, D0..D7, parity (odd unless corrupted), stop
   function automatic logic [10:0] makeFrame(input logic [7:0] b, input bit badPar, input bit badStop);
      logic par;
      par = ~(^b) ^ badPar;
      return {~badStop, par, b, 1'b0};
   endfunction

   // Model of prefix folding: decides what the DUT should report for a completed frame
   task automatic modelFrame(input logic [7:0] b, input bit bad, input int due);
      expEvent_t e;
      e.isErr = bad;
      e.code  = b;
      e.ext   = modelExt;
      e.rel   = modelRel;
      e.due   = due;
      if (bad) begin
         modelExt = 0;
         modelRel = 0;
         expQ.push_back(e);
      end else if (b == 8'hE0) begin
         modelExt = 1;
      end else if (b == 8'hF0) begin
         modelRel = 1;
      end else begin
         expQ.push_back(e);
         lastCode = b;
         lastExt  = modelExt;
         lastRel  = modelRel;
         modelExt = 0;
         modelRel = 0;
      end
   endtask

   // Sends the first nBits of a frame; a full frame is handed to the model at its stop edge
   task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit badStop, input int nBits);
      logic [10:0] fr;
      fr = makeFrame(b, badPar, badStop);
      for (int i = 0; i < nBits; i++) begin
         ps2Data = fr[i];
         repeat (HALF_BIT) @(negedge clock);
         ps2Clk = 1'b0;
         if (i == 10) modelFrame(b, badPar | badStop, cycleCnt + 2);
         if (i == nBits - 1 && nBits < 11) begin
            expQ.push_back('{isErr: 1'b1, code: 8'h00, ext: 1'b0, rel: 1'b0, due: cycleCnt + TIMEOUT + 1});
         end
         repeat (HALF_BIT) @(negedge clock);
         ps2Clk = 1'b1;
      end
      ps2Data = 1'b1;
      repeat (HALF_BIT) @(negedge clock);
   endtask

   task automatic sendFrame(input logic [7:0] b);
      applyStimulus(b, 1'b0, 1'b0, 11);
      checkOutput("hold_code", keyCode, lastCode);
      checkOutput("hold_ext", keyExtended, lastExt);
      checkOutput("hold_rel", keyRelease, lastRel);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_code"}, keyCode, 8'h00);
      checkOutput({tag, "_ext"}, keyExtended, 1'b0);
      checkOutput({tag, "_rel"}, keyRelease, 1'b0);
      checkOutput({tag, "_valid"}, keyValid, 1'b0);
      checkOutput({tag, "_ferr"}, frameError, 1'b0);
   endtask

   // Monitor: one sample per cycle, 1 time unit after the active edge
   initial begin
      expEvent_t e;
      forever begin
         @(posedge clock);
         cycleCnt++;
         #1;
         if (keyValid || frameError) begin
            checkOutput("exclusive", {31'b0, keyValid & frameError}, 32'h0);
            if (expQ.size() == 0) begin
               checkOutput("unexpected", {30'b0, keyValid, frameError}, 32'h0);
            end else begin
               e = expQ.pop_front();
               checkOutput("kind_ferr", {31'b0, frameError}, {31'b0, e.isErr});
               checkOutput("latency", cycleCnt, e.due);
               if (!e.isErr) begin
                  checkOutput("key_code", {24'b0, keyCode}, {24'b0, e.code});
                  checkOutput("key_ext", {31'b0, keyExtended}, {31'b0, e.ext});
                  checkOutput("key_rel", {31'b0, keyRelease}, {31'b0, e.rel});
               end
            end
         end else if (expQ.size() > 0 && cycleCnt > expQ[0].due) begin
            checkOutput("missing", cycleCnt, expQ[0].due);
            void'(expQ.pop_front());
         end
      end
   end

   initial begin
      resetN  = 1'b0;
      ps2Clk  = 1'b1;
      ps2Data = 1'b1;
      repeat (4) @(negedge clock);
      checkResetOutputs("reset");
      resetN = 1'b1;
      repeat (10) @(negedge clock);

      $display("[TB] plain make code 1C");
      sendFrame(8'h1C);

      $display("[TB] idle falling edge with data high is ignored");
      ps2Data = 1'b1;
      repeat (HALF_BIT) @(negedge clock);
      ps2Clk = 1'b0;
      repeat (HALF_BIT) @(negedge clock);
      ps2Clk = 1'b1;
      repeat (HALF_BIT) @(negedge clock);

      $display("[TB] break F0 1C");
      sendFrame(8'hF0);
      sendFrame(8'h1C);

      $display("[TB] extended break E0 F0 75, then 1C, then F0 F0 6B");
      sendFrame(8'hE0);
      sendFrame(8'hF0);
      sendFrame(8'h75);
      sendFrame(8'h1C);
      sendFrame(8'hF0);
      sendFrame(8'hF0);
      sendFrame(8'h6B);

      $display("[TB] bad parity and bad stop frames");
      applyStimulus(8'h1C, 1'b1, 1'b0, 11);
      checkOutput("perr_hold_code", keyCode, lastCode);
      applyStimulus(8'h1C, 1'b0, 1'b1, 11);
      checkOutput("serr_hold_code", keyCode, lastCode);
      applyStimulus(8'h4B, 1'b1, 1'b0, 11);
      checkOutput("perr2_hold_code", keyCode, lastCode);
      checkOutput("perr2_hold_rel", keyRelease, lastRel);

      $display("[TB] corrupted frame discards pending E0");
      sendFrame(8'hE0);
      applyStimulus(8'h33, 1'b0, 1'b1, 11);
      sendFrame(8'h1C);

      $display("[TB] timeout keeps pending F0, then 29");
      sendFrame(8'hF0);
      applyStimulus(8'h29, 1'b0, 1'b0, 5);
      repeat (TIMEOUT + 50) @(negedge clock);
      sendFrame(8'h29);

      $display("[TB] reset mid-frame, then 5A");
      applyStimulus(8'h77, 1'b0, 1'b0, 6);
      void'(expQ.pop_back());
      resetN = 1'b0;
      modelExt = 0;
      modelRel = 0;
      lastCode = 8'h00;
      lastExt  = 0;
      lastRel  = 0;
      repeat (3) @(negedge clock);
      checkResetOutputs("midrst");
      resetN = 1'b1;
      repeat (10) @(negedge clock);
      sendFrame(8'h5A);

      repeat (100) @(negedge clock);
      checkOutput("queue_empty", expQ.size(), 32'h0);

      $display("[TB] Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
